// File: rtl/uart_rx_fifo_pkg.sv
// Purpose : shared receiver FSM encodings and oversample tick constants.
// Latency : n/a (types and constants only).
// Backpres: n/a.
package uart_rx_fifo_pkg;

    // PARITY is only entered when UART_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Oversample counter values: mid start bit, and one full bit period.
    localparam logic [3:0] TICK_MID  = 4'd7;
    localparam logic [3:0] TICK_FULL = 4'd15;

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Purpose : first-word fall-through circular byte buffer with full/empty/overrun.
// Latency : pushed byte visible on rd_data the cycle after wr; pop exposes next head next cycle.
// Backpres: none upstream; a push into a full FIFO without a same-cycle pop is dropped and flagged.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   wr, wr_data    push strobe and byte
//   rd             pop strobe (ignored while empty)
//   rd_data        head byte, forced to 0 while empty
//   empty, full    occupancy flags
//   overrun        one-cycle pulse, registered, the cycle after a dropped push
module uart_rx_byte_fifo #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic          overrun
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          rd_ok;
    logic          wr_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign rd_ok = rd && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_ok = wr && (!full || rd_ok);

    // Storage itself needs no reset: the head is masked while empty.
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            overrun <= wr && !wr_ok;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose : 16x-oversampled UART receiver (LSB first) feeding a FWFT byte FIFO.
// Latency : byte on o_r_data the cycle after the stop-bit sample; i_rx sees a 2-flop sync delay.
// Backpres: none on the line; full FIFO drops the new byte and pulses o_overrun.
//
// Ports:
//   i_clk, i_reset            clock, async active-low reset
//   i_rx                      serial line, idle high, asynchronous
//   i_rd_uart                 pop strobe, one byte per cycle while high
//   o_r_data                  FIFO head byte (0 while empty)
//   o_rx_empty, o_rx_full     FIFO flags
//   o_frame_err, o_overrun    one-cycle error pulses
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 326,
    parameter int DVSR_BIT = 9,
    parameter int FIFO_W   = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_rd_uart,
    output logic [DBIT-1:0] o_r_data,
    output logic            o_rx_empty,
    output logic            o_rx_full,
    output logic            o_frame_err,
    output logic            o_overrun
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    // ------------------------------------------------------------------
    // Line synchronizer; resets to the idle level so reset never looks
    // like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Free-running oversample tick generator.
    // ------------------------------------------------------------------
    logic [DVSR_BIT-1:0] tick_cnt;
    logic                tick;

    assign tick = (tick_cnt == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM.
    // ------------------------------------------------------------------
    rx_state_e       state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            frame_err_q, frame_err_d;
    logic            push;
    logic            stop_ok;

`ifdef UART_RX_PARITY_EN
    logic par_err_q, par_err_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    // A parity mismatch is reported the same way as a bad stop bit.
    assign stop_ok = rx_sync && !par_err_q;
`else
    assign stop_ok = rx_sync;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == TICK_MID) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (!rx_sync) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == TICK_FULL) begin
                        s_d     = '0;
                        shreg_d = {rx_sync, shreg_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == TICK_FULL) begin
                        s_d       = '0;
                        // Even parity: the parity bit equals the XOR of the data bits.
                        par_err_d = rx_sync ^ (^shreg_q);
                        state_d   = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d = ST_IDLE;
                        if (stop_ok) begin
                            push = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_frame_err = frame_err_q;

    uart_rx_byte_fifo #(
        .DW (DBIT),
        .AW (FIFO_W)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .wr      (push),
        .wr_data (shreg_q),
        .rd      (i_rd_uart),
        .rd_data (o_r_data),
        .empty   (o_rx_empty),
        .full    (o_rx_full),
        .overrun (o_overrun)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : directed bench for uart_rx_fifo with an expected-byte scoreboard.
// Latency : frames at 64 clocks/bit (DVSR=4), FIFO depth 4 (FIFO_W=2).
// Backpres: pops driven by the bench; overrun and pop-at-stop cases exercised.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .DBIT     (8),
        .SB_TICK  (16),
        .DVSR     (4),
        .DVSR_BIT (9),
        .FIFO_W   (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx        (rx),
        .i_rd_uart   (rd),
        .o_r_data    (r_data),
        .o_rx_empty  (rx_empty),
        .o_rx_full   (rx_full),
        .o_frame_err (frame_err),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Free-running negedge count; frames start on multiples of 4 so the
    // tick phase relative to every frame is identical between resets.
    int cyc = 0;
    always @(negedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_q[$];
    int         fall_k;
    int         ferr_cnt;
    int         ovr_cnt;
    int         fall_ref;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ferr_cnt += int'(frame_err);
        ovr_cnt  += int'(overrun);
    endtask

    // Sends one 8N1 frame. A bad stop bit is held low for 48 clocks (across
    // the sample point) then released. pop_k>0 pulses rd for one cycle at
    // stop-bit clock pop_k and checks the head against the scoreboard.
    // fall_k records the stop-bit clock at which empty first deasserts.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int pop_k);
        logic [9:0] bits;
        logic       prev_empty;
        bits = {1'b1, d, 1'b0};
        while (cyc % 4 != 0) @(negedge clk);
        fall_k   = -1;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        for (int b = 0; b < 10; b++) begin
            rx = (b == 9) ? stop_ok : bits[b];
            for (int k = 1; k <= 64; k++) begin
                if (b == 9 && !stop_ok && k == 49) rx = 1'b1;
                if (b == 9 && pop_k > 0) begin
                    if (k == pop_k) begin
                        chk8("pop_at_stop_head", r_data, exp_q.pop_front());
                        rd = 1'b1;
                    end else begin
                        rd = 1'b0;
                    end
                end
                prev_empty = rx_empty;
                step();
                if (b == 9 && fall_k < 0 && prev_empty && !rx_empty) fall_k = k;
            end
        end
        rd = 1'b0;
        rx = 1'b1;
        repeat (16) step();
    endtask

    task automatic pop_check(input string tag);
        chk1({tag, "_nonempty"}, rx_empty, 1'b0);
        chk8(tag, r_data, exp_q.pop_front());
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        chk1("rst_empty", rx_empty, 1'b1);
        chk1("rst_full", rx_full, 1'b0);
        chk8("rst_data", r_data, 8'h00);
        chk1("rst_ferr", frame_err, 1'b0);
        chk1("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 0xA5: empty falls about half a bit into the stop bit (sample + 1 clock)
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 0);
        fall_ref = fall_k;
        chk1("a5_fall_window", (fall_k >= 30 && fall_k <= 38), 1'b1);
        chki("a5_no_ferr", ferr_cnt, 0);
        pop_check("a5_data");
        chk1("a5_empty_after_pop", rx_empty, 1'b1);

        // Quarter-bit glitch on idle line
        while (cyc % 4 != 0) @(negedge clk);
        ferr_cnt = 0;
        ovr_cnt  = 0;
        rx = 1'b0;
        repeat (16) step();
        rx = 1'b1;
        repeat (200) step();
        chki("glitch_no_ferr", ferr_cnt, 0);
        chk1("glitch_empty", rx_empty, 1'b1);

        // 0x3F with stop bit low
        send_frame(8'h3F, 1'b0, 0);
        chki("ferr_pulse_count", ferr_cnt, 1);
        chki("ferr_no_push", fall_k, -1);
        chk1("ferr_empty", rx_empty, 1'b1);

        // Fill to full, then overrun on the fifth byte
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 0);
            if (i == 1) chki("fill_fall_consistent", fall_k, fall_ref);
            chki("fill_no_ovr", ovr_cnt, 0);
        end
        chk1("fill_full", rx_full, 1'b1);
        send_frame(8'h05, 1'b1, 0);
        chki("ovr_pulse_count", ovr_cnt, 1);
        chk1("ovr_still_full", rx_full, 1'b1);
        for (int i = 0; i < 4; i++) pop_check("fill_drain");
        chk1("fill_drained_empty", rx_empty, 1'b1);
        chk1("fill_drained_not_full", rx_full, 1'b0);

        // Full FIFO with a pop in the stop-sample cycle of the fifth byte
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h21 + 8'(i));
            send_frame(8'h21 + 8'(i), 1'b1, 0);
        end
        chk1("pps_full_before", rx_full, 1'b1);
        exp_q.push_back(8'h25);
        send_frame(8'h25, 1'b1, fall_ref);
        chki("pps_no_ovr", ovr_cnt, 0);
        chk1("pps_still_full", rx_full, 1'b1);
        for (int i = 0; i < 4; i++) pop_check("pps_drain");
        chk1("pps_drained_empty", rx_empty, 1'b1);

        // Pop while empty is ignored
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        chk1("empty_pop_empty", rx_empty, 1'b1);
        chk1("empty_pop_not_full", rx_full, 1'b0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 0);
        pop_check("after_empty_pop");
        chk1("after_empty_pop_empty", rx_empty, 1'b1);

        // Reset mid-DATA of 0x5A with 0x77 sitting in the FIFO
        send_frame(8'h77, 1'b1, 0);
        chk1("pre_reset_nonempty", rx_empty, 1'b0);
        while (cyc % 4 != 0) @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (8) @(negedge clk);
        chk1("midrst_empty", rx_empty, 1'b1);
        chk1("midrst_full", rx_full, 1'b0);
        chk8("midrst_data", r_data, 8'h00);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 0);
        chki("midrst_no_ferr", ferr_cnt, 0);
        pop_check("midrst_data_12");
        chk1("midrst_only_one", rx_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive half of the debug serial link: 16x-oversampled UART receiver plus byte FIFO feeding the debug controller's command/program stream. Debug controller pops bytes with a read strobe and tests empty; FIFO head is always presented on the data port (first-word fall-through). Sits between the board RX pin and the debug controller; the transmit half is a separate block.

Parameters:
DBIT, 8, data bits per frame (LSB first)
SB_TICK, 16, oversample ticks for stop bit (16 = 1 stop bit)
DVSR, 326, clocks per oversample tick (clk/(baud*16))
DVSR_BIT, 9, width of tick counter
FIFO_W, 5, FIFO address width; depth 2^FIFO_W

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx  in  1  serial line, idle high, asynchronous to i_clk
i_rd_uart  in  1  pop strobe; one byte per cycle while high
o_r_data  out  DBIT  FIFO head byte; valid when o_rx_empty=0
o_rx_empty  out  1  FIFO empty
o_rx_full  out  1  FIFO full
o_frame_err  out  1  one-cycle pulse: stop bit sampled low
o_overrun  out  1  one-cycle pulse: byte dropped, FIFO full

Behaviour:
- Reset (i_reset=0, async assert, sync deassert by design use): FSM IDLE, tick counter 0, pointers 0, o_rx_empty=1, o_rx_full=0, o_r_data=0, pulses 0, sync flops=1.
- i_rx passes a 2-flop synchronizer (reset to 1); FSM sees synchronized value (2-cycle skew).
- Tick gen: counter 0..DVSR-1, tick asserted the cycle counter==DVSR-1, then wraps to 0; free-running.
- FSM states: IDLE, START, DATA, STOP (PARITY when macro set). Sample counter s (4 bit), bit counter n.
  - IDLE: synchronized rx=0 -> START, s=0.
  - START: on tick, s==7 -> if rx=0: DATA, s=0, n=0; if rx=1: IDLE (glitch rejected, nothing pushed). Else s++.
  - DATA: on tick, s==15 -> shift rx into MSB of shift reg (right shift), s=0; n==DBIT-1 -> STOP else n++.
  - STOP: on tick, s==SB_TICK-1 -> rx=1: push byte; rx=0: o_frame_err pulse, no push. -> IDLE either way.
- Push: byte readable on o_r_data, o_rx_empty=0 the cycle after the stop-sample cycle.
- Pop: i_rd_uart=1 and not empty -> read pointer advances; next head visible next cycle. Pop while empty ignored, no pointer change.
- Push while full and no pop: byte dropped, o_overrun pulse, FIFO unchanged. Push and pop same cycle while full: both accepted, stays full. Push and pop same cycle while empty: push only effective (head not yet valid).
- Full/empty from pointers with extra wrap bit; pointers wrap modulo 2^FIFO_W.
- Reset mid-frame: frame discarded; receiver resumes hunting on next falling edge after release.

Optional Feature:
UART_RX_PARITY_EN: defined -> PARITY state after DATA; on tick s==15 samples even-parity bit; mismatch suppresses push and pulses o_frame_err at STOP. Undefined -> no parity bit; DATA goes straight to STOP.

Decomposition:
- Shared package: FSM state encodings, tick midpoint (7) and full-bit (15) constants.
- One sub-module natural: uart_rx_byte_fifo (FWFT circular buffer with full/empty/overrun); receiver FSM and tick gen in top.

Test Plan:
- DVSR=4, send 0xA5 8N1 at 64 clocks/bit -> o_r_data=0xA5, o_rx_empty 1->0 one cycle after stop sample; pop -> empty=1.
- 0.25-bit low glitch on idle line -> no push, no o_frame_err, FSM back in IDLE.
- Frame 0x3F with stop bit held low -> o_frame_err one pulse, o_rx_empty stays 1.
- FIFO_W=2, send 5 bytes 0x01..0x05 without popping -> o_rx_full=1 after 4, o_overrun pulse on 5th; pops return 0x01..0x04.
- Full FIFO, pop held in stop-sample cycle of 5th byte -> 0x05 accepted, no overrun, full stays 1.
- Reset asserted mid-DATA of 0x5A, released, then 0x12 sent -> only 0x12 in FIFO.
